// File: rtl/pipe_control.sv
// pipe_control: opcode decode, three-stage control pipeline (EX/MEM/WB),
// bubble insertion for stall/flush/invalid slots, and a halt FSM that either
// drains older instructions through WB or halts as soon as HLT reaches EX.
module pipe_control #(
  parameter int OP_W       = 4,
  parameter bit HALT_DRAIN = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [OP_W-1:0] op,
  input  logic            id_valid,
  input  logic            stall,
  input  logic            flush,
  output logic [10:0]     ex_ctrl,
  output logic            mem_ctrl,
  output logic [2:0]      wb_ctrl,
  output logic            reg_read,
  output logic            halted,
  output logic            pc_hold
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_HALT  = 2'd2
  } state_t;

  // Full control word as produced by decode; the halt tag travels with it.
  typedef struct packed {
    logic        halt;
    logic [2:0]  wb;
    logic        mem;
    logic [10:0] ex;
  } word_t;

  state_t      state_r;
  state_t      state_n;
  logic [7:0]  op_ext_s;
  logic        op_legal_s;
  word_t       dec_s;
  word_t       ex_next_s;
  logic        load_ok_s;
  logic        halt_enter_s;
  word_t       ex_r;
  logic        mem_we_r;
  logic [2:0]  mem_wb_r;
  logic        mem_halt_r;
  logic [2:0]  wb_r;
  logic        wb_halt_r;
  logic        halted_r;
  logic        reg_read_s;

  // Zero-extend the opcode so that any width from 4 to 6 bits can be range-checked.
  always_comb begin
    op_ext_s             = 8'd0;
    op_ext_s[OP_W-1:0]   = op;
    op_legal_s           = (op_ext_s[7:4] == 4'd0);
  end

  // Opcode decode into the EX/MEM/WB control fields; HLT is tagged, not encoded.
  always_comb begin
    dec_s = '0;
    case (op_ext_s[3:0])
      4'b0000, 4'b0001: begin
        dec_s.ex = {2'b00, op_ext_s[3:0], 3'b111, 2'b00};
        dec_s.wb = 3'b100;
      end
      4'b0010, 4'b0011: begin
        dec_s.ex = {2'b00, op_ext_s[3:0], 3'b100, 2'b00};
        dec_s.wb = 3'b100;
      end
      4'b0100, 4'b0101, 4'b0110: begin
        dec_s.ex = {2'b01, op_ext_s[3:0], 3'b100, 2'b00};
        dec_s.wb = 3'b100;
      end
      4'b0111: begin
        dec_s.ex = {2'b00, op_ext_s[3:0], 3'b000, 2'b00};
        dec_s.wb = 3'b100;
      end
      4'b1000: begin
        dec_s.ex = {2'b10, 4'b0000, 3'b000, 2'b00};
        dec_s.wb = 3'b101;
      end
      4'b1001: begin
        dec_s.ex  = {2'b10, 4'b0000, 3'b000, 2'b00};
        dec_s.mem = 1'b1;
      end
      4'b1010, 4'b1011: begin
        dec_s.ex = {2'b11, op_ext_s[3:0], 3'b000, 2'b00};
        dec_s.wb = 3'b100;
      end
      4'b1100: begin
        dec_s.ex = {2'b00, 4'b0000, 3'b000, 2'b01};
      end
      4'b1101: begin
        dec_s.ex = {2'b00, 4'b0000, 3'b000, 2'b10};
      end
      4'b1110: begin
        dec_s.wb = 3'b110;
      end
      4'b1111: begin
        dec_s.halt = 1'b1;
      end
      default: begin
        dec_s = '0;
      end
    endcase
  end

  // Register-read request for the ID stage: every legal opcode except B, PCS and HLT.
  always_comb begin
    reg_read_s = 1'b0;
    if (op_legal_s) begin
      case (op_ext_s[3:0])
        4'b1100, 4'b1110, 4'b1111: reg_read_s = 1'b0;
        default:                   reg_read_s = 1'b1;
      endcase
    end else begin
      reg_read_s = 1'b0;
    end
  end

  // Choose between the decoded word and a bubble; flush and stall both collapse
  // to one bubble, and only RUN lets real instructions into EX.
  always_comb begin
    load_ok_s    = id_valid && op_legal_s && !flush && !stall && (state_r == ST_RUN);
    halt_enter_s = load_ok_s && dec_s.halt;
    if (load_ok_s) begin
      ex_next_s = dec_s;
    end else begin
      ex_next_s = '0;
    end
  end

  // Halt FSM next-state logic.
  always_comb begin
    state_n = state_r;
    case (state_r)
      ST_RUN: begin
        if (halt_enter_s) begin
          state_n = ST_DRAIN;
        end else begin
          state_n = ST_RUN;
        end
      end
      ST_DRAIN: begin
        if (!HALT_DRAIN || wb_halt_r) begin
          state_n = ST_HALT;
        end else begin
          state_n = ST_DRAIN;
        end
      end
      ST_HALT: begin
        state_n = ST_HALT;
      end
      default: begin
        state_n = ST_RUN;
      end
    endcase
  end

  // Halt FSM state register and the sticky halted flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= ST_RUN;
      halted_r <= 1'b0;
    end else begin
      state_r  <= state_n;
      halted_r <= (state_n == ST_HALT);
    end
  end

  // EX stage register: decoded word or bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_r <= '0;
    end else begin
      ex_r <= ex_next_s;
    end
  end

  // MEM stage register: advances from EX unless the machine is halted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_we_r   <= 1'b0;
      mem_wb_r   <= 3'b000;
      mem_halt_r <= 1'b0;
    end else if (state_r == ST_HALT) begin
      mem_we_r   <= 1'b0;
      mem_wb_r   <= 3'b000;
      mem_halt_r <= 1'b0;
    end else begin
      mem_we_r   <= ex_r.mem;
      mem_wb_r   <= ex_r.wb;
      mem_halt_r <= ex_r.halt;
    end
  end

  // WB stage register: advances from MEM unless the machine is halted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_r      <= 3'b000;
      wb_halt_r <= 1'b0;
    end else if (state_r == ST_HALT) begin
      wb_r      <= 3'b000;
      wb_halt_r <= 1'b0;
    end else begin
      wb_r      <= mem_wb_r;
      wb_halt_r <= mem_halt_r;
    end
  end

  assign ex_ctrl  = ex_r.ex;
  assign mem_ctrl = mem_we_r;
  assign wb_ctrl  = wb_r;
  assign halted   = halted_r;
  assign reg_read = reg_read_s;
  // The PC must freeze in the same cycle a stall is raised, so this stays combinational.
  assign pc_hold  = stall || (state_r != ST_RUN);

endmodule

// File: tb/tb_pipe_control.sv
// Self-checking bench for pipe_control: directed steps, expected values queued
// with their due cycle and compared #1 after the clock edge they mature on.
module tb_pipe_control;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  op;
  logic [4:0]  op5;
  logic        id_valid, stall, flush;

  logic [10:0] ex_ctrl, ex5_ctrl, exn_ctrl;
  logic        mem_ctrl, mem5_ctrl, memn_ctrl;
  logic [2:0]  wb_ctrl, wb5_ctrl, wbn_ctrl;
  logic        reg_read, reg_read5, reg_readn;
  logic        halted, halted5, haltedn;
  logic        pc_hold, pc_hold5, pc_holdn;

  pipe_control #(.OP_W(4), .HALT_DRAIN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .op(op), .id_valid(id_valid), .stall(stall), .flush(flush),
    .ex_ctrl(ex_ctrl), .mem_ctrl(mem_ctrl), .wb_ctrl(wb_ctrl), .reg_read(reg_read),
    .halted(halted), .pc_hold(pc_hold));

  pipe_control #(.OP_W(5), .HALT_DRAIN(1'b1)) dut5 (
    .clk(clk), .rst_n(rst_n), .op(op5), .id_valid(id_valid), .stall(stall), .flush(flush),
    .ex_ctrl(ex5_ctrl), .mem_ctrl(mem5_ctrl), .wb_ctrl(wb5_ctrl), .reg_read(reg_read5),
    .halted(halted5), .pc_hold(pc_hold5));

  pipe_control #(.OP_W(4), .HALT_DRAIN(1'b0)) dutn (
    .clk(clk), .rst_n(rst_n), .op(op), .id_valid(id_valid), .stall(stall), .flush(flush),
    .ex_ctrl(exn_ctrl), .mem_ctrl(memn_ctrl), .wb_ctrl(wbn_ctrl), .reg_read(reg_readn),
    .halted(haltedn), .pc_hold(pc_holdn));

  always #5 clk = ~clk;

  localparam int K_EX = 0, K_MEM = 1, K_WB = 2, K_HALT = 3, K_PCH = 4, K_EX5 = 5, K_HALTN = 6;

  typedef struct {
    int          due;
    int          kind;
    logic [10:0] val;
    string       tag;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  logic [10:0] t_ex[16];
  logic        t_mem[16];
  logic [2:0]  t_wb[16];
  logic        t_rr[16];

  function automatic logic [10:0] observe(int kind);
    case (kind)
      K_EX:    return ex_ctrl;
      K_MEM:   return {10'd0, mem_ctrl};
      K_WB:    return {8'd0, wb_ctrl};
      K_HALT:  return {10'd0, halted};
      K_PCH:   return {10'd0, pc_hold};
      K_EX5:   return ex5_ctrl;
      K_HALTN: return {10'd0, haltedn};
      default: return 11'h7ff;
    endcase
  endfunction

  task automatic check(string tag, logic [10:0] obs, logic [10:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic push(int dly, int kind, logic [10:0] v, string tag);
    exp_t e;
    e.due  = cyc + dly;
    e.kind = kind;
    e.val  = v;
    e.tag  = tag;
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    for (int i = exp_q.size() - 1; i >= 0; i--) begin
      if (exp_q[i].due == cyc) begin
        check(exp_q[i].tag, observe(exp_q[i].kind), exp_q[i].val);
        exp_q.delete(i);
      end
    end
  endtask

  initial begin
    // Expected decode table written directly from the opcode map.
    t_ex[0]  = 11'b00_0000_111_00; t_ex[1]  = 11'b00_0001_111_00;
    t_ex[2]  = 11'b00_0010_100_00; t_ex[3]  = 11'b00_0011_100_00;
    t_ex[4]  = 11'b01_0100_100_00; t_ex[5]  = 11'b01_0101_100_00;
    t_ex[6]  = 11'b01_0110_100_00; t_ex[7]  = 11'b00_0111_000_00;
    t_ex[8]  = 11'b10_0000_000_00; t_ex[9]  = 11'b10_0000_000_00;
    t_ex[10] = 11'b11_1010_000_00; t_ex[11] = 11'b11_1011_000_00;
    t_ex[12] = 11'b00_0000_000_01; t_ex[13] = 11'b00_0000_000_10;
    t_ex[14] = 11'd0;              t_ex[15] = 11'd0;
    for (int i = 0; i < 16; i++) begin
      t_mem[i] = (i == 9) ? 1'b1 : 1'b0;
      t_rr[i]  = (i == 12 || i == 14 || i == 15) ? 1'b0 : 1'b1;
      if (i <= 7 || i == 10 || i == 11) t_wb[i] = 3'b100;
      else if (i == 8)                  t_wb[i] = 3'b101;
      else if (i == 14)                 t_wb[i] = 3'b110;
      else                              t_wb[i] = 3'b000;
    end

    // Asynchronous reset before any clock edge.
    rst_n = 1'b1; op = 4'd0; op5 = 5'd0; id_valid = 1'b0; stall = 1'b0; flush = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("reset ex_ctrl", ex_ctrl, 11'd0);
    check("reset mem_ctrl", {10'd0, mem_ctrl}, 11'd0);
    check("reset wb_ctrl", {8'd0, wb_ctrl}, 11'd0);
    check("reset halted", {10'd0, halted}, 11'd0);
    check("reset pc_hold", {10'd0, pc_hold}, 11'd0);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Opcode sweep 0..14 (HLT handled separately).
    id_valid = 1'b1;
    for (int i = 0; i < 15; i++) begin
      op = 4'(i);
      #1;
      check($sformatf("reg_read op%0d", i), {10'd0, reg_read}, {10'd0, t_rr[i]});
      push(1, K_EX,  t_ex[i],             $sformatf("ex op%0d", i));
      push(2, K_MEM, {10'd0, t_mem[i]},   $sformatf("mem op%0d", i));
      push(3, K_WB,  {8'd0, t_wb[i]},     $sformatf("wb op%0d", i));
      tick();
    end
    op = 4'd15; id_valid = 1'b0;
    #1;
    check("reg_read op15", {10'd0, reg_read}, 11'd0);
    push(1, K_EX, 11'd0, "ex idle bubble");
    tick(); tick(); tick();

    // SW followed by a stalled ADD: SW reaches MEM, EX holds a bubble.
    op = 4'd9; id_valid = 1'b1;
    push(1, K_EX, t_ex[9], "ex sw");
    push(2, K_MEM, 11'd1, "mem sw after stall");
    tick();
    op = 4'd0; stall = 1'b1;
    #1;
    check("pc_hold on stall", {10'd0, pc_hold}, 11'd1);
    push(1, K_EX, 11'd0, "ex stall bubble");
    push(3, K_WB, 11'd0, "wb stall bubble");
    tick();
    stall = 1'b0; flush = 1'b1; op = 4'd1;
    push(1, K_EX, 11'd0, "ex flush bubble");
    tick();
    stall = 1'b1; flush = 1'b1; op = 4'd2;
    push(1, K_EX, 11'd0, "ex stall+flush bubble");
    tick();
    stall = 1'b0; flush = 1'b0; id_valid = 1'b0; op = 4'd1;
    push(1, K_EX, 11'd0, "ex invalid bubble");
    tick();

    // Five-bit opcode instance: out-of-range opcode is a NOP, SUB decodes normally.
    id_valid = 1'b1; op = 4'd3; op5 = 5'b10000;
    push(1, K_EX5, 11'd0, "ex5 op16 bubble");
    tick();
    op5 = 5'b00001;
    push(1, K_EX5, t_ex[1], "ex5 sub");
    tick();
    op5 = 5'd0;

    // HLT flushed in ID is cancelled.
    op = 4'd15; flush = 1'b1;
    push(1, K_EX, 11'd0, "ex flushed hlt");
    push(1, K_PCH, 11'd0, "pc_hold after flushed hlt");
    push(3, K_HALT, 11'd0, "halted after flushed hlt");
    push(2, K_HALTN, 11'd0, "haltedn after flushed hlt");
    tick();
    flush = 1'b0;

    // LW then HLT back-to-back; later ops must be ignored.
    op = 4'd8;
    push(1, K_EX, t_ex[8], "ex lw");
    push(3, K_WB, 11'b101, "wb lw before halt");
    tick();
    op = 4'd15;
    push(1, K_EX, 11'd0, "ex hlt word");
    push(1, K_PCH, 11'd1, "pc_hold in drain");
    push(3, K_WB, 11'd0, "wb hlt word");
    push(3, K_HALT, 11'd0, "halted not yet");
    push(4, K_HALT, 11'd1, "halted after drain");
    push(1, K_HALTN, 11'd0, "haltedn at hlt in ex");
    push(2, K_HALTN, 11'd1, "haltedn next cycle");
    tick();
    for (int i = 0; i < 5; i++) begin
      op = (i % 2 == 0) ? 4'd0 : 4'd9;
      push(1, K_EX,  11'd0, $sformatf("ex ignored %0d", i));
      push(2, K_MEM, 11'd0, $sformatf("mem ignored %0d", i));
      push(3, K_WB,  11'd0, $sformatf("wb ignored %0d", i));
      tick();
    end
    check("pc_hold in halt", {10'd0, pc_hold}, 11'd1);
    check("halted sticky", {10'd0, halted}, 11'd1);

    // Reset pulse between edges while halted.
    #2 rst_n = 1'b0;
    #1;
    check("mid reset halted", {10'd0, halted}, 11'd0);
    check("mid reset haltedn", {10'd0, haltedn}, 11'd0);
    check("mid reset ex_ctrl", ex_ctrl, 11'd0);
    check("mid reset wb_ctrl", {8'd0, wb_ctrl}, 11'd0);
    check("mid reset pc_hold", {10'd0, pc_hold}, 11'd0);
    #1 rst_n = 1'b1;
    op = 4'd0; id_valid = 1'b1;
    push(1, K_EX, t_ex[0], "ex add after reset");
    push(3, K_WB, 11'b100, "wb add after reset");
    tick();
    id_valid = 1'b0;
    tick(); tick(); tick();

    check("scoreboard drained", 11'(exp_q.size()), 11'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
